// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
//
// Turns a raw asynchronous pin (button, switch, external strobe) into a clean
// level that is synchronous to clk_i. The pin first passes through a
// SYNC_STAGES-deep synchronizer. A four-state debounce FSM then accepts a new
// level only after DEBOUNCE_CYCLES consecutive synchronized samples agree.
// signal_o is meant to drive an edge detector directly.
//
// Ports
//   clk_i     system clock, all logic on posedge
//   rst_i     synchronous reset, active-high
//   async_i   raw asynchronous input
//   bypass_i  1 = skip debounce, signal_o follows the synchronized input
//   signal_o  debounced level (flop output)
//   busy_o    1 while a candidate transition is being qualified
// -----------------------------------------------------------------------------
module input_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter int   CNT_WIDTH       = 16,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  input  logic bypass_i,
  output logic signal_o,
  output logic busy_o
);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_e;

  // Counter value on which the candidate level is accepted.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam state_e               RST_STATE = RESET_VALUE ? S_HIGH : S_LOW;

  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic                   sync_q;
  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   signal_q;

  // Plain shift chain; nothing between stages so each flop gets a full cycle
  // to resolve metastability.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_chain_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  // Debounce FSM. cnt_q counts consecutive samples of the candidate level;
  // it restarts at 1 on every new candidate and is cleared on acceptance or
  // rejection, so it never exceeds CNT_LAST.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      signal_q <= RESET_VALUE;
    end else if (bypass_i) begin
      // Keep state consistent with the output so that dropping bypass_i
      // resumes from a settled state without a glitch.
      signal_q <= sync_q;
      state_q  <= sync_q ? S_HIGH : S_LOW;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_LOW: begin
          if (sync_q) begin
            state_q <= S_RISE;
            cnt_q   <= CNT_ONE;
          end
        end
        S_RISE: begin
          if (!sync_q) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= S_HIGH;
            signal_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!sync_q) begin
            state_q <= S_FALL;
            cnt_q   <= CNT_ONE;
          end
        end
        S_FALL: begin
          if (sync_q) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= S_LOW;
            signal_q <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= RST_STATE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign signal_o = signal_q;
  // Pure decode of the state register: no combinational path from inputs.
  assign busy_o   = (state_q == S_RISE) || (state_q == S_FALL);

endmodule

// File: tb/tb_input_debounce.sv
// -----------------------------------------------------------------------------
// tb_input_debounce
//
// Self-checking bench for input_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// RESET_VALUE=0). Every clock goes through step(): the bench's own reference
// model (sync pipeline plus a "consecutive samples of the other level"
// counter) pushes the expected {signal_o, busy_o} into exp_q, the clock
// edge is taken, and the entry is popped and compared #1 later. A vector
// table covers reset and a clean rise with hand-derived values. Scripted
// sequences cover glitches, bounce, the fall path, bypass and reset while
// qualifying.
// -----------------------------------------------------------------------------
module tb_input_debounce;

  localparam int   SS = 2;
  localparam int   DC = 4;
  localparam int   CW = 16;
  localparam logic RV = 1'b0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  logic async_i;
  logic bypass_i;
  logic signal_o;
  logic busy_o;

  always #5 clk = ~clk;

  input_debounce #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH      (CW),
    .RESET_VALUE    (RV)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .async_i (async_i),
    .bypass_i(bypass_i),
    .signal_o(signal_o),
    .busy_o  (busy_o)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];   // {signal_o, busy_o}

  // Reference model state.
  logic [SS-1:0] m_sync = {SS{RV}};
  logic          m_sig  = RV;
  int            m_run  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic a, input logic b);
    logic sq;
    if (r) begin
      m_sync = {SS{RV}};
      m_sig  = RV;
      m_run  = 0;
    end else begin
      sq     = m_sync[SS-1];
      m_sync = {m_sync[SS-2:0], a};
      if (b) begin
        m_sig = sq;
        m_run = 0;
      end else if (sq != m_sig) begin
        m_run++;
        if (m_run == DC) begin
          m_sig = sq;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic a, input logic b);
    logic [1:0] exp;
    rst_i    = r;
    async_i  = a;
    bypass_i = b;
    model_edge(r, a, b);
    exp_q.push_back({m_sig, (m_run != 0)});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("model", {30'd0, signal_o, busy_o}, {30'd0, exp});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst;
    logic a;
    logic byp;
    logic sig;
    logic busy;
  } vec_t;

  vec_t vecs[13];

  int   rises;
  int   idx;
  logic prev_sig;
  logic saw;
  logic saw_busy;
  logic a_hist[$];

  initial begin
    rst_i    = 1'b1;
    async_i  = 1'b0;
    bypass_i = 1'b0;

    // Reset held 3 clocks with async_i=1, then a clean rise.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // E1: sync stage 0 loads
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // E2: sync_q goes high
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};  // E3: candidate, cnt=1
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};  // E6: accepted
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].a, vecs[i].byp);
      check($sformatf("vec%0d", i), {30'd0, signal_o, busy_o},
            {30'd0, vecs[i].sig, vecs[i].busy});
    end
    // Hold high: no further change.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
    check("rise_hold", {31'd0, signal_o}, 32'd1);

    // ---- fall path: 3-clock low excursion rejected ----
    saw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      saw &= signal_o;
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0);
      saw &= signal_o;
    end
    check("fall_reject", {31'd0, saw}, 32'd1);

    // ---- fall path: 10-clock low accepted after SS+DC-1 steps ----
    idx = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (idx < 0 && signal_o == 1'b0) idx = i;
    end
    check("fall_latency", idx, SS + DC - 1);
    check("fall_level", {31'd0, signal_o}, 32'd0);

    // ---- glitch: 3-clock high rejected, busy pulses ----
    saw      = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      saw |= signal_o;
      saw_busy |= busy_o;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      saw |= signal_o;
      saw_busy |= busy_o;
    end
    check("glitch3_sig", {31'd0, saw}, 32'd0);
    check("glitch3_busy", {31'd0, saw_busy}, 32'd1);

    // ---- 4-clock high is exactly long enough ----
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      saw |= signal_o;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      saw |= signal_o;
    end
    check("glitch4_accept", {31'd0, saw}, 32'd1);
    check("glitch4_back_low", {31'd0, signal_o}, 32'd0);

    // ---- bounce: one clean rise, 4 edges after the stable run ----
    begin
      logic bounce[9];
      bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      rises    = 0;
      idx      = -1;
      prev_sig = signal_o;
      for (int i = 0; i < 17; i++) begin
        step(1'b0, (i < 9) ? bounce[i] : 1'b1, 1'b0);
        if (!prev_sig && signal_o) begin
          rises++;
          if (idx < 0) idx = i;
        end
        prev_sig = signal_o;
      end
    end
    check("bounce_rises", rises, 1);
    check("bounce_rise_step", idx, 5 + SS + DC - 1);

    // ---- bypass: follow sync_q with 2-clock delay, busy stays 0 ----
    saw_busy = 1'b0;
    a_hist.delete();
    for (int i = 0; i < 12; i++) begin
      logic a;
      a = ((i / 2) % 2) == 0 ? 1'b0 : 1'b1;
      a_hist.push_back(a);
      step(1'b0, a, 1'b1);
      saw_busy |= busy_o;
      if (i >= SS) check($sformatf("bypass_follow%0d", i), {31'd0, signal_o}, {31'd0, a_hist[i-SS]});
    end
    check("bypass_busy", {31'd0, saw_busy}, 32'd0);
    // Leave bypass with a steady input; no glitch expected (model-checked).
    for (int i = 0; i < 4; i++) step(1'b0, a_hist[11], 1'b0);

    // ---- reset while qualifying a rise at cnt=2 ----
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    check("midop_busy", {31'd0, busy_o}, 32'd1);
    check("midop_cnt", {16'd0, dut.cnt_q}, 32'd2);
    step(1'b1, 1'b1, 1'b0);
    check("midop_rst_sig", {31'd0, signal_o}, 32'd0);
    check("midop_rst_busy", {31'd0, busy_o}, 32'd0);
    check("midop_rst_cnt", {16'd0, dut.cnt_q}, 32'd0);
    // After release the full synchronizer + debounce latency applies again.
    idx = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (idx < 0 && signal_o) idx = i;
    end
    check("post_rst_latency", idx, SS + DC - 1);

    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
